// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt source codes, fetch FSM states and flag positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        INT_NONE = 2'd0,
        INT_IRQ  = 2'd1,
        INT_NMI  = 2'd2,
        INT_RST  = 2'd3
    } int_src_e;

    typedef enum logic {
        RST_HOLD = 1'b0,
        RUN      = 1'b1
    } fetch_state_e;

    localparam logic [7:0] OP_BRK_CODE = 8'h00;
    localparam int unsigned FL_I = 2;

endpackage

// File: rtl/opcode_fetch_if.sv
// Sequencer <-> opcode fetch stage bundle; master is the sequencer/bus side.
interface opcode_fetch_if;
    import cpu_pkg::*;

    logic        rdy;
    logic        sync;
    logic        op_lo_we;
    logic        op_hi_we;
    logic [7:0]  data_i;
    logic [7:0]  pstatus;
    logic        irq_n;
    logic        nmi_n;
    logic [7:0]  opcode;
    logic [15:0] operand;
    int_src_e    int_src;
    logic        inc_pc;
    logic        fetch_busy;

    modport master (
        output rdy, sync, op_lo_we, op_hi_we, data_i, pstatus, irq_n, nmi_n,
        input  opcode, operand, int_src, inc_pc, fetch_busy
    );

    modport slave (
        input  rdy, sync, op_lo_we, op_hi_we, data_i, pstatus, irq_n, nmi_n,
        output opcode, operand, int_src, inc_pc, fetch_busy
    );

endinterface

// File: rtl/int_edge_det.sv
// Falling-edge detector with sticky pending flag; FETCH_INT_SYNC_EN adds a 2-flop synchroniser.
module int_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sig_n,
    input  logic clr,
    output logic pend
);

    logic level_n;
    logic prev_q;
    logic pend_q;

`ifdef FETCH_INT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sig_n};
        end
    end

    assign level_n = sync_q[1];
`else
    assign level_n = sig_n;
`endif

    // Clear beats a simultaneous new edge: that edge is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else if (en) begin
            prev_q <= level_n;
            if (clr) begin
                pend_q <= 1'b0;
            end else if (prev_q && !level_n) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/opcode_fetch.sv
// Instruction register with RESET/NMI/IRQ BRK injection and operand latches.
// FETCH_INT_SYNC_EN: synchronise irq_n/nmi_n through 2 flops before use.
module opcode_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned RST_VEC_CYCLES = 2,
    parameter int unsigned FL_I_BIT       = FL_I
) (
    input logic           clk,
    input logic           rst_n,
    opcode_fetch_if.slave bus
);

    fetch_state_e state_q, state_d;
    logic [7:0]   rst_hold_q, rst_hold_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [15:0]  operand_q, operand_d;
    int_src_e     int_src_q, int_src_d;
    logic         rst_pend_q, rst_pend_d;
    logic         nmi_pend;
    logic         nmi_clr;
    logic         irq_n_s;
    logic         irq_act;
    logic         inc_pc;

`ifdef FETCH_INT_SYNC_EN
    logic [1:0] irq_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= 2'b11;
        end else begin
            irq_sync_q <= {irq_sync_q[0], bus.irq_n};
        end
    end

    assign irq_n_s = irq_sync_q[1];
`else
    assign irq_n_s = bus.irq_n;
`endif

    assign irq_act = !irq_n_s && !bus.pstatus[FL_I_BIT];

    int_edge_det u_nmi_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.rdy),
        .sig_n (bus.nmi_n),
        .clr   (nmi_clr),
        .pend  (nmi_pend)
    );

    always_comb begin
        state_d    = state_q;
        rst_hold_d = rst_hold_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        int_src_d  = int_src_q;
        rst_pend_d = rst_pend_q;
        nmi_clr    = 1'b0;
        inc_pc     = 1'b0;

        if (bus.rdy) begin
            unique case (state_q)
                RST_HOLD: begin
                    if (rst_hold_q != 8'd0) begin
                        rst_hold_d = rst_hold_q - 8'd1;
                    end
                    // Leave as the count reaches zero so the next cycle can fetch.
                    if (rst_hold_q <= 8'd1) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.sync) begin
                        operand_d = 16'h0000;
                        opcode_d  = OP_BRK_CODE;
                        if (rst_pend_q) begin
                            int_src_d  = INT_RST;
                            rst_pend_d = 1'b0;
                        end else if (nmi_pend) begin
                            int_src_d = INT_NMI;
                            nmi_clr   = 1'b1;
                        end else if (irq_act) begin
                            int_src_d = INT_IRQ;
                        end else begin
                            opcode_d  = bus.data_i;
                            int_src_d = INT_NONE;
                            inc_pc    = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // An operand write coinciding with sync is illegal; sync takes precedence.
            if (!bus.sync) begin
                if (bus.op_lo_we) begin
                    operand_d[7:0] = bus.data_i;
                end
                if (bus.op_hi_we) begin
                    operand_d[15:8] = bus.data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_HOLD;
            rst_hold_q <= 8'(RST_VEC_CYCLES);
            opcode_q   <= OP_BRK_CODE;
            operand_q  <= 16'h0000;
            int_src_q  <= INT_RST;
            rst_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= rst_hold_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            int_src_q  <= int_src_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    assign bus.opcode     = opcode_q;
    assign bus.operand    = operand_q;
    assign bus.int_src    = int_src_q;
    assign bus.inc_pc     = inc_pc;
    assign bus.fetch_busy = (state_q == RST_HOLD);

endmodule

// File: tb/tb_opcode_fetch.sv
// Self-checking bench for opcode_fetch: directed scenarios plus randomized run against a model.
module tb_opcode_fetch;
    import cpu_pkg::*;

    localparam int RST_CYC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    opcode_fetch_if bus ();

    opcode_fetch #(
        .RST_VEC_CYCLES (RST_CYC),
        .FL_I_BIT       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per rising edge.
    logic [7:0]  m_opcode;
    logic [15:0] m_operand;
    int          m_src;
    int          m_busy;
    bit          m_rst_pend;
    bit          m_nmi_pend;
    bit          m_nmi_prev;
    logic        got_inc;
    logic        exp_inc;

    function automatic void model_reset();
        m_opcode   = 8'h00;
        m_operand  = 16'h0000;
        m_src      = 3;
        m_busy     = RST_CYC;
        m_rst_pend = 1'b1;
        m_nmi_pend = 1'b0;
        m_nmi_prev = 1'b1;
    endfunction

    function automatic bit model_irq();
        return !bus.irq_n && !bus.pstatus[2];
    endfunction

    function automatic bit model_inc();
        return bus.rdy && bus.sync && m_busy == 0 && !m_rst_pend && !m_nmi_pend && !model_irq();
    endfunction

    function automatic void model_edge();
        bit fell;
        bit took_nmi;
        fell = m_nmi_prev && !bus.nmi_n;
        took_nmi = 1'b0;
        if (!bus.rdy) return;
        if (bus.sync && m_busy == 0) begin
            m_operand = 16'h0000;
            if (m_rst_pend) begin
                m_opcode = 8'h00; m_src = 3; m_rst_pend = 1'b0;
            end else if (m_nmi_pend) begin
                m_opcode = 8'h00; m_src = 2; m_nmi_pend = 1'b0; took_nmi = 1'b1;
            end else if (model_irq()) begin
                m_opcode = 8'h00; m_src = 1;
            end else begin
                m_opcode = bus.data_i; m_src = 0;
            end
        end else if (!bus.sync) begin
            if (bus.op_lo_we) m_operand[7:0] = bus.data_i;
            if (bus.op_hi_we) m_operand[15:8] = bus.data_i;
        end
        if (fell && !took_nmi) m_nmi_pend = 1'b1;
        if (m_busy > 0) m_busy--;
        m_nmi_prev = bus.nmi_n;
    endfunction

    task automatic drive(input bit r, input bit s, input bit lo, input bit hi, input logic [7:0] d);
        bus.rdy = r; bus.sync = s; bus.op_lo_we = lo; bus.op_hi_we = hi; bus.data_i = d;
    endtask

    // One clock: sample inc_pc mid-cycle, advance model at the edge, settle past it.
    task automatic tick();
        @(negedge clk);
        exp_inc = model_inc();
        got_inc = bus.inc_pc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 8'h00);
        bus.pstatus = 8'h04; bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
        apply_reset();
        total++; if (bus.opcode !== 8'h00) begin bad++; $display("FAIL rst_opcode got=%h want=00", bus.opcode); end
        total++; if (bus.operand !== 16'h0000) begin bad++; $display("FAIL rst_operand got=%h want=0000", bus.operand); end
        total++; if (bus.int_src !== INT_RST) begin bad++; $display("FAIL rst_src got=%0d want=3", bus.int_src); end
        total++; if (bus.fetch_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", bus.fetch_busy); end
        release_reset();
        tick();
        total++; if (bus.fetch_busy !== 1'b1) begin bad++; $display("FAIL hold_busy1 got=%b want=1", bus.fetch_busy); end
        tick();
        total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL hold_busy2 got=%b want=0", bus.fetch_busy); end
    endtask

    task automatic test_first_fetch();
        drive(1, 1, 0, 0, 8'hA9);
        tick();
        total++; if (got_inc !== 1'b0) begin bad++; $display("FAIL ff_rst_inc got=%b want=0", got_inc); end
        total++; if (bus.opcode !== 8'h00) begin bad++; $display("FAIL ff_rst_op got=%h want=00", bus.opcode); end
        total++; if (bus.int_src !== INT_RST) begin bad++; $display("FAIL ff_rst_src got=%0d want=3", bus.int_src); end
        tick();
        total++; if (got_inc !== 1'b1) begin bad++; $display("FAIL ff_inc got=%b want=1", got_inc); end
        total++; if (bus.opcode !== 8'hA9) begin bad++; $display("FAIL ff_op got=%h want=a9", bus.opcode); end
        total++; if (bus.int_src !== INT_NONE) begin bad++; $display("FAIL ff_src got=%0d want=0", bus.int_src); end
    endtask

    task automatic test_irq();
        bus.irq_n = 1'b0; bus.pstatus = 8'h00;
        drive(1, 1, 0, 0, 8'h69);
        tick();
        total++; if (got_inc !== 1'b0) begin bad++; $display("FAIL irq_inc got=%b want=0", got_inc); end
        total++; if (bus.opcode !== 8'h00) begin bad++; $display("FAIL irq_op got=%h want=00", bus.opcode); end
        total++; if (bus.int_src !== INT_IRQ) begin bad++; $display("FAIL irq_src got=%0d want=1", bus.int_src); end
        bus.pstatus = 8'h04;
        tick();
        total++; if (got_inc !== 1'b1) begin bad++; $display("FAIL irqmask_inc got=%b want=1", got_inc); end
        total++; if (bus.opcode !== 8'h69) begin bad++; $display("FAIL irqmask_op got=%h want=69", bus.opcode); end
    endtask

    task automatic test_nmi();
        bus.irq_n = 1'b0; bus.pstatus = 8'h00;
        drive(1, 0, 0, 0, 8'hEA);
        bus.nmi_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        drive(1, 1, 0, 0, 8'hEA);
        tick();
        total++; if (bus.int_src !== INT_NMI) begin bad++; $display("FAIL nmi_src got=%0d want=2", bus.int_src); end
        tick();
        total++; if (bus.int_src !== INT_IRQ) begin bad++; $display("FAIL nmi_hold_src got=%0d want=1", bus.int_src); end
        bus.nmi_n = 1'b1; bus.irq_n = 1'b1;
    endtask

    task automatic test_operand();
        drive(1, 1, 0, 0, 8'hAD); tick();
        drive(1, 0, 1, 0, 8'h34); tick();
        drive(1, 0, 0, 1, 8'h12); tick();
        total++; if (bus.operand !== 16'h1234) begin bad++; $display("FAIL opnd got=%h want=1234", bus.operand); end
        total++; if (bus.opcode !== 8'hAD) begin bad++; $display("FAIL opnd_op got=%h want=ad", bus.opcode); end
        drive(1, 1, 1, 1, 8'h77); tick();
        total++; if (bus.operand !== 16'h0000) begin bad++; $display("FAIL opnd_clr got=%h want=0000", bus.operand); end
        total++; if (bus.opcode !== 8'h77) begin bad++; $display("FAIL opnd_sync_op got=%h want=77", bus.opcode); end
    endtask

    task automatic test_rdy();
        drive(0, 1, 0, 0, 8'hEA);
        bus.nmi_n = 1'b0;
        tick();
        total++; if (got_inc !== 1'b0) begin bad++; $display("FAIL rdy_inc got=%b want=0", got_inc); end
        total++; if (bus.opcode !== 8'h77) begin bad++; $display("FAIL rdy_op got=%h want=77", bus.opcode); end
        tick();
        drive(1, 0, 0, 0, 8'hEA); tick();
        drive(1, 1, 0, 0, 8'hEA); tick();
        total++; if (bus.int_src !== INT_NMI) begin bad++; $display("FAIL rdy_nmi got=%0d want=2", bus.int_src); end
        bus.nmi_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 8'h00);
        bus.nmi_n = 1'b0; tick();
        bus.nmi_n = 1'b1; tick();
        apply_reset();
        total++; if (bus.int_src !== INT_RST) begin bad++; $display("FAIL mid_src got=%0d want=3", bus.int_src); end
        total++; if (bus.fetch_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus.fetch_busy); end
        release_reset();
        drive(1, 1, 0, 0, 8'h55); tick();
        total++; if (got_inc !== 1'b0 || bus.opcode !== 8'h00) begin
            bad++; $display("FAIL mid_hold_sync got=%b/%h want=0/00", got_inc, bus.opcode);
        end
        drive(1, 0, 0, 0, 8'h00); tick();
        total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_end got=%b want=0", bus.fetch_busy); end
        drive(1, 1, 0, 0, 8'h11); tick();
        total++; if (bus.int_src !== INT_RST) begin bad++; $display("FAIL mid_first got=%0d want=3", bus.int_src); end
        tick();
        total++; if (bus.int_src !== INT_NONE || bus.opcode !== 8'h11) begin
            bad++; $display("FAIL mid_nmi_gone got=%0d/%h want=0/11", bus.int_src, bus.opcode);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(7) != 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, 8'($urandom));
            bus.pstatus = 8'($urandom);
            bus.irq_n = 1'($urandom);
            if ($urandom_range(7) == 0) bus.nmi_n = ~bus.nmi_n;
            tick();
            total++; if (got_inc !== exp_inc) begin bad++; $display("FAIL rnd_inc[%0d] got=%b want=%b", i, got_inc, exp_inc); end
            total++; if (bus.opcode !== m_opcode) begin bad++; $display("FAIL rnd_op[%0d] got=%h want=%h", i, bus.opcode, m_opcode); end
            total++; if (bus.operand !== m_operand) begin bad++; $display("FAIL rnd_opnd[%0d] got=%h want=%h", i, bus.operand, m_operand); end
            total++; if (bus.int_src !== 2'(m_src)) begin bad++; $display("FAIL rnd_src[%0d] got=%0d want=%0d", i, bus.int_src, m_src); end
            total++; if (bus.fetch_busy !== (m_busy > 0)) begin bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", i, bus.fetch_busy, m_busy > 0); end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 8'h00);
        bus.pstatus = 8'h04; bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
        model_reset();
        test_reset();
        test_first_fetch();
        test_irq();
        test_nmi();
        test_operand();
        test_rdy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
